// File: rtl/sync_fifo_flex_if.sv
// sync_fifo_flex_if: handshake/data bundle for sync_fifo_flex.
//
// Handshake semantics: wr_en is a write request that is taken on the rising
// edge when the FIFO is not full, or when it is full and a read is taken in
// the same cycle. rd_en is a read/pop request that is taken on the rising edge
// when the FIFO is not empty. A request that is not taken changes no state and
// raises the matching *_err pulse on the following cycle.
//
// Signals:
//   wr_en, wdata          producer -> FIFO  write request and data
//   rd_en                 consumer -> FIFO  read/pop request
//   rdata                 FIFO -> consumer  read data
//   full, empty           FIFO -> both      occupancy == DEPTH / == 0
//   almost_full/empty     FIFO -> both      programmable threshold flags
//   count                 FIFO -> both      occupancy 0..DEPTH
//   wr_err, rd_err        FIFO -> both      one-cycle rejected-request pulses
interface sync_fifo_flex_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic             rd_en;
    logic [WIDTH-1:0] rdata;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             wr_err;
    logic             rd_err;

    // Producer/consumer side.
    modport master (
        output wr_en, wdata, rd_en,
        input  rdata, full, empty, almost_full, almost_empty, count, wr_err, rd_err
    );

    // FIFO side.
    modport slave (
        input  wr_en, wdata, rd_en,
        output rdata, full, empty, almost_full, almost_empty, count, wr_err, rd_err
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO for any DEPTH >= 2, with standard
// (registered, one-cycle read latency) or first-word-fall-through read mode,
// occupancy count, programmable almost-full/almost-empty flags and
// rejected-request error pulses.
//
// Ports:
//   clk   rising-edge clock for all state
//   rst   synchronous active-high reset (clears pointers, count, rdata, errors;
//         memory contents are kept)
//   bus   sync_fifo_flex_if.slave: wr_en/wdata/rd_en in; rdata, full, empty,
//         almost_full, almost_empty, count, wr_err, rd_err out
module sync_fifo_flex #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int PTR_W    = $clog2(DEPTH),
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input logic               clk,
    input logic               rst,
    sync_fifo_flex_if.slave   bus
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             wr_err_q;
    logic             rd_err_q;
    logic             is_empty;
    logic             is_full;
    logic             rd_ok;
    logic             wr_ok;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNT_W'(DEPTH));

    // A write to a full FIFO is still taken when a read frees a slot in the
    // same cycle. On an empty FIFO the read is refused; no bypass.
    assign rd_ok = bus.rd_en & ~is_empty;
    assign wr_ok = bus.wr_en & (~is_full | rd_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
            if (wr_ok && !rd_ok) begin
                cnt <= cnt + CNT_W'(1);
            end else if (rd_ok && !wr_ok) begin
                cnt <= cnt - CNT_W'(1);
            end
            wr_err_q <= bus.wr_en & ~wr_ok;
            rd_err_q <= bus.rd_en & ~rd_ok;
        end
    end

    // Storage has no reset; a write in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr] <= bus.wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible whenever the FIFO is non-empty.
            assign bus.rdata = mem[rd_ptr];
        end else begin : g_std
            logic [WIDTH-1:0] rdata_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (rd_ok) begin
                    rdata_q <= mem[rd_ptr];
                end
            end
            assign bus.rdata = rdata_q;
        end
    endgenerate

    assign bus.count        = cnt;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_full  = (cnt >= CNT_W'(AF_LEVEL));
    assign bus.almost_empty = (cnt <= CNT_W'(AE_LEVEL));
    assign bus.wr_err       = wr_err_q;
    assign bus.rd_err       = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: drives three FIFO configurations with identical stimulus
// (DEPTH=16 standard, DEPTH=5 standard, DEPTH=16 FWFT) and compares every
// output each cycle against a queue-based reference model per configuration.
module tb_sync_fifo_flex;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    sync_fifo_flex_if #(.WIDTH(16), .DEPTH(16)) b0 ();
    sync_fifo_flex_if #(.WIDTH(16), .DEPTH(5))  b1 ();
    sync_fifo_flex_if #(.WIDTH(16), .DEPTH(16)) b2 ();

    sync_fifo_flex #(.WIDTH(16), .DEPTH(16), .FWFT(0)) u_d16 (.clk(clk), .rst(rst), .bus(b0));
    sync_fifo_flex #(.WIDTH(16), .DEPTH(5),  .FWFT(0)) u_d5  (.clk(clk), .rst(rst), .bus(b1));
    sync_fifo_flex #(.WIDTH(16), .DEPTH(16), .FWFT(1)) u_fw  (.clk(clk), .rst(rst), .bus(b2));

    logic [15:0] o_rdata [3];
    logic [4:0]  o_count [3];
    logic        o_full  [3];
    logic        o_empty [3];
    logic        o_af    [3];
    logic        o_ae    [3];
    logic        o_werr  [3];
    logic        o_rerr  [3];

    assign o_rdata[0] = b0.rdata;  assign o_rdata[1] = b1.rdata;  assign o_rdata[2] = b2.rdata;
    assign o_count[0] = b0.count;  assign o_count[1] = {2'b00, b1.count};  assign o_count[2] = b2.count;
    assign o_full[0]  = b0.full;   assign o_full[1]  = b1.full;   assign o_full[2]  = b2.full;
    assign o_empty[0] = b0.empty;  assign o_empty[1] = b1.empty;  assign o_empty[2] = b2.empty;
    assign o_af[0] = b0.almost_full;  assign o_af[1] = b1.almost_full;  assign o_af[2] = b2.almost_full;
    assign o_ae[0] = b0.almost_empty; assign o_ae[1] = b1.almost_empty; assign o_ae[2] = b2.almost_empty;
    assign o_werr[0] = b0.wr_err;  assign o_werr[1] = b1.wr_err;  assign o_werr[2] = b2.wr_err;
    assign o_rerr[0] = b0.rd_err;  assign o_rerr[1] = b1.rd_err;  assign o_rerr[2] = b2.rd_err;

    // ---------------- reference model ----------------
    int          dep  [3] = '{16, 5, 16};
    int          fwft [3] = '{0, 0, 1};
    logic [15:0] exp_q [3][$];
    logic [15:0] m_rdata [3];
    logic        m_werr  [3];
    logic        m_rerr  [3];

    task automatic model_update(input int k, input logic w, input logic [15:0] d,
                                input logic r, input logic rs);
        logic rd_take;
        logic wr_take;
        logic [15:0] head;
        if (rs) begin
            exp_q[k].delete();
            m_rdata[k] = 16'h0;
            m_werr[k]  = 1'b0;
            m_rerr[k]  = 1'b0;
        end else begin
            rd_take = r && (exp_q[k].size() > 0);
            wr_take = w && ((exp_q[k].size() < dep[k]) || rd_take);
            if (rd_take) begin
                head = exp_q[k].pop_front();
                if (fwft[k] == 0) m_rdata[k] = head;
            end
            if (wr_take) exp_q[k].push_back(d);
            m_werr[k] = w && !wr_take;
            m_rerr[k] = r && !rd_take;
        end
    endtask

    // ---------------- scoreboard ----------------
    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int sz;
        for (int k = 0; k < 3; k++) begin
            sz = exp_q[k].size();
            check($sformatf("u%0d.count", k), 32'(o_count[k]), 32'(sz));
            check($sformatf("u%0d.empty", k), 32'(o_empty[k]), 32'(sz == 0));
            check($sformatf("u%0d.full", k),  32'(o_full[k]),  32'(sz == dep[k]));
            check($sformatf("u%0d.almost_full", k),  32'(o_af[k]), 32'(sz >= dep[k] - 2));
            check($sformatf("u%0d.almost_empty", k), 32'(o_ae[k]), 32'(sz <= 2));
            check($sformatf("u%0d.wr_err", k), 32'(o_werr[k]), 32'(m_werr[k]));
            check($sformatf("u%0d.rd_err", k), 32'(o_rerr[k]), 32'(m_rerr[k]));
            if (fwft[k] == 0) begin
                check($sformatf("u%0d.rdata", k), 32'(o_rdata[k]), 32'(m_rdata[k]));
            end else if (sz > 0) begin
                check($sformatf("u%0d.rdata_head", k), 32'(o_rdata[k]), 32'(exp_q[k][0]));
            end
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change after the falling edge; outputs are checked at the next
    // falling edge, once the model has absorbed the rising edge.
    task automatic step(input logic w, input logic [15:0] d, input logic r, input logic rs);
        b0.wr_en = w; b1.wr_en = w; b2.wr_en = w;
        b0.wdata = d; b1.wdata = d; b2.wdata = d;
        b0.rd_en = r; b1.rd_en = r; b2.rd_en = r;
        rst = rs;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_update(k, w, d, r, rs);
        @(negedge clk);
        check_all();
    endtask

    task automatic write_word(input logic [15:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic read_word();
        step(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int k = 0; k < 3; k++) begin
            m_rdata[k] = 16'h0;
            m_werr[k]  = 1'b0;
            m_rerr[k]  = 1'b0;
        end
        rst = 1'b1;
        b0.wr_en = 1'b0; b1.wr_en = 1'b0; b2.wr_en = 1'b0;
        b0.rd_en = 1'b0; b1.rd_en = 1'b0; b2.rd_en = 1'b0;
        b0.wdata = '0;   b1.wdata = '0;   b2.wdata = '0;
        @(negedge clk);

        // Reset, then idle.
        step(1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        idle();
        idle();

        // Fill with 1..16, overflow with DEAD, drain 16, underflow once.
        for (int i = 1; i <= 16; i++) write_word(16'(i));
        write_word(16'hDEAD);
        idle();
        for (int i = 0; i < 17; i++) read_word();
        idle();

        // Repeated fill/drain of five words: exercises wrap on DEPTH=5.
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int i = 0; i < 5; i++) write_word(16'(16'h0100 * (rnd + 1) + i));
            for (int i = 0; i < 5; i++) read_word();
        end
        idle();

        // Pass-through at full.
        for (int i = 0; i < 16; i++) write_word(16'(16'h0200 + i));
        for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h00A0 + i), 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) read_word();
        idle();

        // Empty with both requested: write taken, read refused, no bypass.
        step(1'b1, 16'h0055, 1'b1, 1'b0);
        idle();
        read_word();
        idle();

        // Reset mid-operation with both requests active.
        for (int i = 0; i < 8; i++) write_word(16'(16'h0300 + i));
        step(1'b1, 16'hBAD0, 1'b1, 1'b1);
        idle();
        write_word(16'h0077);
        read_word();
        idle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 55,
                 16'($urandom_range(0, 65535)),
                 $urandom_range(0, 99) < 50,
                 $urandom_range(0, 199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Parametrised single-clock FIFO, next generation of the team's synchronous FIFO.
- Supports any DEPTH ≥ 2 (not only powers of two).
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Exposes occupancy count, programmable almost-full/almost-empty flags and per-cycle overflow/underflow error pulses.
- Sits between producer/consumer blocks in the same clock domain; it is the drop-in buffer for UVM-verified datapaths.

Parameters:
- WIDTH, 16, data word width in bits (≥1).
- DEPTH, 16, number of storage entries (≥2, any integer).
- FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency); 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1).
- PTR_W, $clog2(DEPTH), pointer width (derived; do not override).
- CNT_W, $clog2(DEPTH+1), count width (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- wdata  input  WIDTH  write data, sampled with wr_en.
- rd_en  input  1  read/pop request.
- rdata  output  WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count ≥ AF_LEVEL.
- almost_empty  output  1  count ≤ AE_LEVEL.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- wr_err  output  1  registered pulse: a write was rejected in the previous cycle.
- rd_err  output  1  registered pulse: a read was rejected in the previous cycle.

Behaviour:
- Reset (rst=1 at edge): pointers=0, count=0, rdata=0, wr_err=0, rd_err=0. Hence empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not cleared.
- Reset has priority over all requests. Reset mid-operation discards all stored data; a write or read issued in the reset cycle is ignored and raises no error.
- Flags are decoded combinationally from the registered count, so they change in the same cycle as count.
- Acceptance, evaluated on pre-edge state:
  - rd_ok = rd_en & !empty.
  - wr_ok = wr_en & (!full | rd_ok). A write to a full FIFO is accepted when a read is accepted in the same cycle (pass-through at full).
  - Empty with both requested: write accepted, read rejected; the new word is not bypassed.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- Pointers: advance by 1 on acceptance. On reaching DEPTH-1 they wrap to 0 explicitly; no power-of-two arithmetic is assumed.
- Errors: next wr_err = wr_en & !wr_ok; next rd_err = rd_en & !rd_ok. Each is a 1-cycle pulse per rejected request; a rejected request changes no other state.
- FWFT=0:
  - On rd_ok, rdata <= mem[rd_ptr]; data is valid the cycle after the accepted rd_en.
  - rdata holds its value otherwise, including on rejected reads.
- FWFT=1:
  - rdata = mem[rd_ptr] combinationally whenever empty=0; rd_en acknowledges/pops the head.
  - A word written to an empty FIFO appears on rdata the cycle after the write (once empty deasserts).
  - rdata is don't-care while empty=1; the bench must not check it then.
- Data order is strictly FIFO across any number of wrap-arounds.

Test Plan:
- Reset then idle, DEPTH=16 → count=0, empty=1, almost_empty=1, full=0, almost_full=0, rdata=0, wr_err=rd_err=0.
- FWFT=0, write 0x0001..0x0010 (16 writes), one more write of 0xDEAD → full=1 and almost_full=1 from count=14; wr_err=1 for exactly one cycle after the 17th write; then 16 reads return 0x0001..0x0010, each one cycle after its rd_en; 17th read → rd_err=1, rdata holds 0x0010.
- DEPTH=5 (non-power-of-two), 3 write/read cycles of 5 words each → pointer wrap correct, data in order, count returns to 0.
- Full FIFO (DEPTH=16), wr_en=rd_en=1 for 4 cycles with 0xA0..0xA3 → count stays 16, wr_err=rd_err=0, the 4 oldest words are read out, 0xA0..0xA3 are read out last.
- Empty FIFO, wr_en=rd_en=1 with 0x55 → rd_err=1 next cycle, count=1. FWFT=1: rdata=0x55 on the following cycle, without rd_en.
- Fill to count=8, assert rst for one cycle while wr_en=rd_en=1 → next cycle count=0, empty=1, no error pulses; a subsequent write/read returns the new data only.
